mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side responder for the instruction cache's miss interface, plus a load/store port for the LSB.
- Serializes word/half/byte accesses onto the byte-wide synchronous RAM bus.
- Assembles little-endian results and returns them with a one-cycle done pulse.
- Sits between the icache/LSB and the top-level RAM/IO bus.

Parameters:
- IO_BASE, 32'h30000, addresses >= this are IO-mapped and subject to io_buffer_full stall.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- ready  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush
- ic_req_flag  in  1  icache miss request, held high until served
- ic_pc  in  32  fetch address
- ic_out_flag  out  1  one-cycle pulse: ic_ins valid
- ic_ins  out  32  fetched instruction
- ls_req_flag  in  1  LSB request, held high until served
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- ls_addr  in  32  access address
- ls_wdata  in  32  store data, low bytes used
- ls_out_flag  out  1  one-cycle done pulse, for loads and stores
- ls_rdata  out  32  load data, zero-extended
- ram_din  in  8  RAM read byte, valid the cycle after the RAM latches ram_a
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (reset low, async): state=IDLE.
  - All outputs 0: ic_out_flag, ic_ins, ls_out_flag, ls_rdata, ram_a, ram_dout, ram_wr.
  - Byte counter cleared.
- States: IDLE, IC_READ, LS_READ, LS_WRITE, DONE.
- Request arbitration, in IDLE only:
  - ls_req_flag has priority over ic_req_flag.
  - The request is sampled at edge E0, and address/size/data are latched at E0.
  - n = 1/2/4 bytes for ls_size 0/1/2; an IC read is always 4 bytes.
- Read timing:
  - Byte k address is driven on ram_a after edge Ek; ram_wr=0.
  - Byte k is captured from ram_din at E(k+2) into bits [8k+7:8k].
  - After E(n+1): result is on ic_ins or ls_rdata, the matching out_flag is 1, state=DONE.
  - Word read: done pulse visible after E5.
- Write timing:
  - After edge Ek (k<n): ram_a=addr+k, ram_dout=ls_wdata[8k+7:8k], ram_wr=1.
  - After En: ram_wr=0, ls_out_flag=1, state=DONE.
  - Word store: done pulse visible after E4.
- IO stall:
  - Applies when a byte is about to be written, the address is >= IO_BASE, and io_buffer_full=1.
  - ram_wr is driven 0 and the byte index is held until io_buffer_full=0.
  - Reads are never stalled.
- DONE:
  - Out flags are high for exactly this one cycle; state then returns to IDLE.
  - Requests are ignored in DONE because the requester drops its flag on the same edge it consumes the result.
  - This guarantees no duplicate access is started.
- Out flags are 0 in every state other than DONE. ic_ins and ls_rdata hold their last value.
- clear, sampled at a rising edge:
  - An IC_READ or LS_READ in progress is aborted: state=IDLE, no out_flag pulse, ram_wr=0.
  - An LS_WRITE in progress always completes, since stores are committed.
  - clear in DONE suppresses nothing; the pulse has already been issued.
  - clear in IDLE discards that cycle's request.
- ready=0:
  - All registers hold.
  - ram_wr is forced 0 combinationally; a write byte is re-issued when ready returns.
- Address wrap: addr+k is computed mod 2^32.
- Simultaneous ic and ls requests: the LS request is served first. IC is served on the first IDLE after its DONE, provided ic_req_flag is still high.

Test Plan:
- IC word read, ic_pc=0x1000, RAM bytes 0x13,0x05,0x00,0x00:
  - ram_a is 0x1000..0x1003 over 4 cycles.
  - ic_out_flag pulses 1 cycle, 5 edges after sampling, with ic_ins=0x00000513.
  - No second read is started in the following cycle.
- Store word 0xDEADBEEF to 0x2000:
  - ram_wr=1 with (a,dout) = (0x2000,EF),(0x2001,BE),(0x2002,AD),(0x2003,DE) on consecutive cycles.
  - ls_out_flag pulses after E4.
- Concurrent ic_req_flag and LS byte load at 0x10:
  - LS is served first: ls_rdata=0x000000XX, pulse after E2.
  - IC read starts after the DONE cycle.
- IO store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles:
  - ram_wr stays 0 for 3 cycles.
  - Then exactly one write of 0x41 occurs, followed by the ls_out_flag pulse.
- clear asserted during the 3rd cycle of an IC read:
  - No ic_out_flag pulse; state returns to IDLE.
  - A new ic_req is accepted next cycle and returns correct data.
- Reset low mid-store (after byte 1):
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a word load of 0x2000 returns the partially written bytes consistently.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the icache miss port and the LSB
// load/store port. Serializes 1/2/4-byte accesses onto a byte-wide
// synchronous RAM bus. Loads are reassembled little-endian and zero-extended.
// Every access ends with a one-cycle done pulse in the DONE state.
//
// Handshake: a requester raises its req_flag and holds it until it sees its
// out_flag high for one cycle. It drops the flag on the edge that leaves
// DONE, and DONE never samples requests, so no access is ever duplicated.

module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        clear,
    input  logic        ic_req_flag,
    input  logic [31:0] ic_pc,
    output logic        ic_out_flag,
    output logic [31:0] ic_ins,
    input  logic        ls_req_flag,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_out_flag,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IC_READ  = 3'd1,
        LS_READ  = 3'd2,
        LS_WRITE = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] base_addr;   // address of byte 0 of the current access
    logic [31:0] wdata_q;     // store data latched at acceptance
    logic [31:0] rbuf;        // partially assembled load result
    logic [2:0]  len;         // access length in bytes: 1, 2 or 4
    logic [2:0]  cnt;         // read: edge index; write: byte being written
    logic        wr_q;        // registered write strobe before gating

    logic [2:0]  cnt_inc;
    logic [1:0]  cap_idx;
    logic [1:0]  next_idx;
    logic [31:0] rd_next;
    logic [7:0]  wbyte_next;
    logic        io_stall;

    // Byte count for an LSB request; size 3 is treated as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            2'd0:    size_to_len = 3'd1;
            2'd1:    size_to_len = 3'd2;
            default: size_to_len = 3'd4;
        endcase
    endfunction

    assign cnt_inc  = cnt + 3'd1;
    // At read edge E(k+2) the byte captured is k, i.e. cnt-2 (mod 4).
    assign cap_idx  = cnt[1:0] - 2'd2;
    assign next_idx = cnt_inc[1:0];

    // IO writes wait while the IO buffer is full; reads are never stalled.
    assign io_stall = (state == LS_WRITE) && (ram_a >= IO_BASE) && io_buffer_full;

    // The write strobe is dropped while frozen or stalled so the byte is
    // re-issued once the bus can take it.
    assign ram_wr = wr_q && ready && !io_stall;

    // Merge the byte arriving on ram_din into its lane of the load result.
    always_comb begin
        rd_next = rbuf;
        case (cap_idx)
            2'd0: rd_next[7:0]   = ram_din;
            2'd1: rd_next[15:8]  = ram_din;
            2'd2: rd_next[23:16] = ram_din;
            2'd3: rd_next[31:24] = ram_din;
            default: rd_next = rbuf;
        endcase
    end

    // Select the next store byte to put on ram_dout.
    always_comb begin
        wbyte_next = wdata_q[7:0];
        case (next_idx)
            2'd0: wbyte_next = wdata_q[7:0];
            2'd1: wbyte_next = wdata_q[15:8];
            2'd2: wbyte_next = wdata_q[23:16];
            2'd3: wbyte_next = wdata_q[31:24];
            default: wbyte_next = wdata_q[7:0];
        endcase
    end

    // Main controller: arbitration, byte sequencing, result return.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base_addr   <= 32'h0;
            wdata_q     <= 32'h0;
            rbuf        <= 32'h0;
            len         <= 3'd0;
            cnt         <= 3'd0;
            wr_q        <= 1'b0;
            ic_out_flag <= 1'b0;
            ic_ins      <= 32'h0;
            ls_out_flag <= 1'b0;
            ls_rdata    <= 32'h0;
            ram_a       <= 32'h0;
            ram_dout    <= 8'h0;
        end else if (ready) begin
            case (state)
                IDLE: begin
                    // A flush in IDLE discards this cycle's request.
                    if (!clear) begin
                        if (ls_req_flag) begin
                            base_addr <= ls_addr;
                            ram_a     <= ls_addr;
                            len       <= size_to_len(ls_size);
                            wdata_q   <= ls_wdata;
                            rbuf      <= 32'h0;
                            if (ls_wr) begin
                                cnt      <= 3'd0;
                                ram_dout <= ls_wdata[7:0];
                                wr_q     <= 1'b1;
                                state    <= LS_WRITE;
                            end else begin
                                cnt   <= 3'd1;
                                state <= LS_READ;
                            end
                        end else if (ic_req_flag) begin
                            base_addr <= ic_pc;
                            ram_a     <= ic_pc;
                            len       <= 3'd4;
                            rbuf      <= 32'h0;
                            cnt       <= 3'd1;
                            state     <= IC_READ;
                        end
                    end
                end

                IC_READ, LS_READ: begin
                    if (clear) begin
                        // Reads are speculative and can be abandoned silently.
                        state <= IDLE;
                        wr_q  <= 1'b0;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt >= 3'd2) begin
                            rbuf <= rd_next;
                        end
                        if (cnt < len) begin
                            ram_a <= base_addr + {29'h0, cnt};
                        end
                        if (cnt == len + 3'd1) begin
                            state <= DONE;
                            cnt   <= 3'd0;
                            if (state == IC_READ) begin
                                ic_ins      <= rd_next;
                                ic_out_flag <= 1'b1;
                            end else begin
                                ls_rdata    <= rd_next;
                                ls_out_flag <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                LS_WRITE: begin
                    // Stores are committed: clear is ignored here.
                    if (!io_stall) begin
                        if (cnt_inc < len) begin
                            cnt      <= cnt_inc;
                            ram_a    <= base_addr + {29'h0, cnt_inc};
                            ram_dout <= wbyte_next;
                        end else begin
                            wr_q        <= 1'b0;
                            ls_out_flag <= 1'b1;
                            cnt         <= 3'd0;
                            state       <= DONE;
                        end
                    end
                end

                DONE: begin
                    // Requests are not sampled here; the requester is
                    // dropping its flag on this very edge.
                    ic_out_flag <= 1'b0;
                    ls_out_flag <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    wr_q        <= 1'b0;
                    ic_out_flag <= 1'b0;
                    ls_out_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule
